// File: rtl/axi_mem_pkg.sv
// Shared types and helpers for the 64-bit AXI3 slave memory.
package axi_mem_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam int         AXI_ADDR_MAX_W = 64;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

   // INCR bursts only: each beat advances by the beat size in bytes.
   function automatic logic [AXI_ADDR_MAX_W-1:0] next_addr(
      input logic [AXI_ADDR_MAX_W-1:0] addr,
      input logic [1:0]                size);
      return addr + (AXI_ADDR_MAX_W'(1) << size);
   endfunction

endpackage

// File: rtl/axi64_slave_mem_if.sv
// AXI3 channel bundle (AW/W/B/AR/R) for the 64-bit slave memory.
interface axi64_slave_mem_if #(
   parameter int ID_W   = 1,
   parameter int ADDR_W = 32
);
   logic [ID_W-1:0]   AWID;
   logic [ADDR_W-1:0] AWADDR;
   logic [3:0]        AWLEN;
   logic [1:0]        AWSIZE;
   logic              AWVALID, AWREADY;
   logic [ID_W-1:0]   WID;
   logic [63:0]       WDATA;
   logic [7:0]        WSTRB;
   logic              WLAST, WVALID, WREADY;
   logic [ID_W-1:0]   BID;
   logic [1:0]        BRESP;
   logic              BVALID, BREADY;
   logic [ID_W-1:0]   ARID;
   logic [ADDR_W-1:0] ARADDR;
   logic [3:0]        ARLEN;
   logic [1:0]        ARSIZE;
   logic              ARVALID, ARREADY;
   logic [ID_W-1:0]   RID;
   logic [63:0]       RDATA;
   logic [1:0]        RRESP;
   logic              RLAST, RVALID, RREADY;

   modport master (
      output AWID, AWADDR, AWLEN, AWSIZE, AWVALID, input AWREADY,
      output WID, WDATA, WSTRB, WLAST, WVALID, input WREADY,
      input BID, BRESP, BVALID, output BREADY,
      output ARID, ARADDR, ARLEN, ARSIZE, ARVALID, input ARREADY,
      input RID, RDATA, RRESP, RLAST, RVALID, output RREADY
   );

   modport slave (
      input AWID, AWADDR, AWLEN, AWSIZE, AWVALID, output AWREADY,
      input WID, WDATA, WSTRB, WLAST, WVALID, output WREADY,
      output BID, BRESP, BVALID, input BREADY,
      input ARID, ARADDR, ARLEN, ARSIZE, ARVALID, output ARREADY,
      output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
   );
endinterface

// File: rtl/axi_mem_array.sv
// 2^MEM_AW x 64 storage: one byte-strobed write port, one registered read port.
module axi_mem_array #(
   parameter int MEM_AW = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [MEM_AW-1:0] waddr,
   input  logic [63:0]       wdata,
   input  logic [7:0]        wstrb,
   input  logic              re,
   input  logic [MEM_AW-1:0] raddr,
   output logic [63:0]       rdata
);
   logic [63:0] mem [0:(1<<MEM_AW)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 8; b++) begin
            if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Same-edge read of a word being written returns the old contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)   rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/axi64_slave_mem.sv
// 64-bit AXI3 slave memory with independent read/write engines, one burst each.
// Define AXI_MEM_WAIT_EN to stall AWREADY/ARREADY/WREADY for WAIT_CYCLES on state entry.
module axi64_slave_mem
   import axi_mem_pkg::*;
#(
   parameter int ID_W        = 1,
   parameter int ADDR_W      = 32,
   parameter int MEM_AW      = 10,
   parameter int WAIT_CYCLES = 3
) (
   input  logic              clk,
   input  logic              reset,
   axi64_slave_mem_if.slave  axi
);
   localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(64'd8 << MEM_AW);

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return a < MEM_BYTES;
   endfunction

   wstate_t           w_state, w_state_n;
   rstate_t           r_state, r_state_n;
   logic              armed, w_go, r_go;
   logic              awready, wready, bvalid, arready, rvalid, rlast;
   logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [ID_W-1:0]   w_id, r_id;
   logic [ADDR_W-1:0] w_addr, r_addr, w_addr_nxt, r_addr_nxt;
   logic [3:0]        w_len, w_cnt, r_len, r_cnt;
   logic [1:0]        w_size, r_size;
   logic              w_err, r_oor, wr_en, rd_en;
   logic [MEM_AW-1:0] rd_word;
   logic [63:0]       arr_q;
   logic              unused_wid;

   assign unused_wid = ^axi.WID;

   // Keeps readies low while reset is held and for the first edge after it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) armed <= 1'b0;
      else       armed <= 1'b1;
   end

`ifdef AXI_MEM_WAIT_EN
   logic [7:0] w_wait, r_wait;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_wait <= 8'(WAIT_CYCLES);
         r_wait <= 8'(WAIT_CYCLES);
      end else begin
         if (w_state_n != w_state)  w_wait <= 8'(WAIT_CYCLES);
         else if (w_wait != 8'd0)   w_wait <= w_wait - 8'd1;
         if (r_state_n != r_state)  r_wait <= 8'(WAIT_CYCLES);
         else if (r_wait != 8'd0)   r_wait <= r_wait - 8'd1;
      end
   end

   assign w_go = armed && (w_wait == 8'd0);
   assign r_go = armed && (r_wait == 8'd0);
`else
   logic unused_wait;
   assign unused_wait = WAIT_CYCLES[0];
   assign w_go = armed;
   assign r_go = armed;
`endif

   assign aw_hs = awready & axi.AWVALID;
   assign w_hs  = wready  & axi.WVALID;
   assign b_hs  = bvalid  & axi.BREADY;
   assign ar_hs = arready & axi.ARVALID;
   assign r_hs  = rvalid  & axi.RREADY;

   assign w_addr_nxt = ADDR_W'(next_addr(AXI_ADDR_MAX_W'(w_addr), w_size));
   assign r_addr_nxt = ADDR_W'(next_addr(AXI_ADDR_MAX_W'(r_addr), r_size));

   // ---------------- write engine ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) w_state <= W_IDLE;
      else       w_state <= w_state_n;
   end

   always_comb begin
      w_state_n = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs)               w_state_n = W_DATA;
         W_DATA:  if (w_hs && axi.WLAST)   w_state_n = W_RESP;
         W_RESP:  if (b_hs)                w_state_n = W_IDLE;
         default:                          w_state_n = W_IDLE;
      endcase
   end

   always_comb begin
      awready = (w_state == W_IDLE) && w_go;
      wready  = (w_state == W_DATA) && w_go;
      bvalid  = (w_state == W_RESP);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_id   <= '0;
         w_addr <= '0;
         w_len  <= '0;
         w_size <= '0;
         w_cnt  <= '0;
         w_err  <= 1'b0;
      end else if (aw_hs) begin
         w_id   <= axi.AWID;
         w_addr <= axi.AWADDR;
         w_len  <= axi.AWLEN;
         w_size <= axi.AWSIZE;
         w_cnt  <= '0;
         w_err  <= 1'b0;
      end else if (w_hs) begin
         w_addr <= w_addr_nxt;
         w_cnt  <= w_cnt + 4'd1;
         // WLAST must coincide exactly with beat index LEN.
         if (!in_range(w_addr) || (axi.WLAST != (w_cnt == w_len))) w_err <= 1'b1;
      end
   end

   assign wr_en = w_hs && in_range(w_addr);

   // ---------------- read engine ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= R_IDLE;
      else       r_state <= r_state_n;
   end

   always_comb begin
      r_state_n = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs)           r_state_n = R_DATA;
         R_DATA:  if (r_hs && rlast)   r_state_n = R_IDLE;
         default:                      r_state_n = R_IDLE;
      endcase
   end

   always_comb begin
      arready = (r_state == R_IDLE) && r_go;
      rvalid  = (r_state == R_DATA);
      rlast   = rvalid && (r_cnt == r_len);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_id   <= '0;
         r_addr <= '0;
         r_len  <= '0;
         r_size <= '0;
         r_cnt  <= '0;
         r_oor  <= 1'b0;
      end else if (ar_hs) begin
         r_id   <= axi.ARID;
         r_addr <= axi.ARADDR;
         r_len  <= axi.ARLEN;
         r_size <= axi.ARSIZE;
         r_cnt  <= '0;
         r_oor  <= !in_range(axi.ARADDR);
      end else if (r_hs && !rlast) begin
         r_addr <= r_addr_nxt;
         r_cnt  <= r_cnt + 4'd1;
         r_oor  <= !in_range(r_addr_nxt);
      end
   end

   // Prefetch the next beat on each handshake so data is ready the following cycle.
   assign rd_en   = ar_hs || (r_hs && !rlast);
   assign rd_word = ar_hs ? axi.ARADDR[MEM_AW+2:3] : r_addr_nxt[MEM_AW+2:3];

   axi_mem_array #(.MEM_AW(MEM_AW)) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en),
      .waddr (w_addr[MEM_AW+2:3]),
      .wdata (axi.WDATA),
      .wstrb (axi.WSTRB),
      .re    (rd_en),
      .raddr (rd_word),
      .rdata (arr_q)
   );

   assign axi.AWREADY = awready;
   assign axi.WREADY  = wready;
   assign axi.BVALID  = bvalid;
   assign axi.BID     = w_id;
   assign axi.BRESP   = w_err ? RESP_SLVERR : RESP_OKAY;
   assign axi.ARREADY = arready;
   assign axi.RVALID  = rvalid;
   assign axi.RLAST   = rlast;
   assign axi.RID     = r_id;
   assign axi.RRESP   = r_oor ? RESP_SLVERR : RESP_OKAY;
   assign axi.RDATA   = r_oor ? 64'd0 : arr_q;
endmodule

// File: tb/tb_axi64_slave_mem.sv
// Self-checking bench for axi64_slave_mem: directed scenarios plus random bursts
// checked against a byte-level memory model.
module tb_axi64_slave_mem;
   localparam int ID_W      = 1;
   localparam int ADDR_W    = 32;
   localparam int MEM_WORDS = 1024;
   localparam int MEM_BYTES = 8192;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   axi64_slave_mem_if #(.ID_W(ID_W), .ADDR_W(ADDR_W)) axi ();

   axi64_slave_mem #(.ID_W(ID_W), .ADDR_W(ADDR_W), .MEM_AW(10), .WAIT_CYCLES(3)) dut (
      .clk   (clk),
      .reset (reset),
      .axi   (axi.slave)
   );

   int          checks = 0;
   int          errors = 0;
   logic [63:0] mem_m [MEM_WORDS];
   logic [63:0] wd_q [$];
   logic [7:0]  ws_q [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return axi.AWREADY;
         1:       return axi.WREADY;
         2:       return axi.BVALID;
         3:       return axi.ARREADY;
         4:       return axi.RVALID;
         default: return 1'b0;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge where the signal is seen high.
   task automatic wait_for(input int which, input string tag);
      int n = 0;
      while (!sig(which) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(sig(which)), 64'(1));
   endtask

   task automatic bus_idle();
      axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = '0; axi.AWVALID = 1'b0;
      axi.WID = '0; axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.WVALID = 1'b0;
      axi.BREADY = 1'b0;
      axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = '0; axi.ARVALID = 1'b0;
      axi.RREADY = 1'b0;
   endtask

   // Burst of wd_q/ws_q beats; expected BRESP derived from beat count and range.
   task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] size, input int bdelay);
      int          nb;
      bit          err;
      logic [31:0] a;
      int          w;
      nb  = wd_q.size();
      err = (nb != len + 1);
      a   = addr;
      for (int i = 0; i < nb; i++) begin
         if (a >= MEM_BYTES) err = 1'b1;
         else begin
            w = int'(a >> 3);
            for (int b = 0; b < 8; b++)
               if (ws_q[i][b]) mem_m[w][8*b +: 8] = wd_q[i][8*b +: 8];
         end
         a = a + (32'd1 << size);
      end
      axi.AWID = id; axi.AWADDR = addr; axi.AWLEN = 4'(len); axi.AWSIZE = size;
      axi.AWVALID = 1'b1;
      wait_for(0, "awready");
      @(negedge clk);
      axi.AWVALID = 1'b0;
      for (int i = 0; i < nb; i++) begin
         axi.WDATA = wd_q[i]; axi.WSTRB = ws_q[i]; axi.WLAST = (i == nb - 1);
         axi.WID = id; axi.WVALID = 1'b1;
         wait_for(1, "wready");
         @(negedge clk);
      end
      axi.WVALID = 1'b0; axi.WLAST = 1'b0;
      chk("bvalid_after_wlast", 64'(axi.BVALID), 64'(1));
      for (int d = 0; d < bdelay; d++) begin
         @(negedge clk);
         chk("bvalid_hold", 64'(axi.BVALID), 64'(1));
      end
      axi.BREADY = 1'b1;
      chk("bid", 64'(axi.BID), 64'(id));
      chk("bresp", 64'(axi.BRESP), 64'(err ? 2'b10 : 2'b00));
      @(negedge clk);
      axi.BREADY = 1'b0;
      chk("bvalid_drop", 64'(axi.BVALID), 64'(0));
      wd_q.delete();
      ws_q.delete();
   endtask

   // mode 0: RREADY always high, 1: one stall cycle per beat, 2: random stalls.
   task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] size, input int mode);
      logic [31:0] a;
      bit          oor, stall;
      logic [63:0] expd;
      axi.ARID = id; axi.ARADDR = addr; axi.ARLEN = 4'(len); axi.ARSIZE = size;
      axi.ARVALID = 1'b1;
      wait_for(3, "arready");
      @(negedge clk);
      axi.ARVALID = 1'b0;
      chk("rvalid_first", 64'(axi.RVALID), 64'(1));
      a = addr;
      for (int i = 0; i <= len; i++) begin
         oor   = (a >= MEM_BYTES);
         expd  = oor ? 64'd0 : mem_m[int'(a >> 3)];
         stall = (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
         if (stall) begin
            axi.RREADY = 1'b0;
            wait_for(4, "rvalid");
            @(negedge clk);
            chk("rvalid_stall", 64'(axi.RVALID), 64'(1));
            chk("rdata_stall", axi.RDATA, expd);
            chk("rlast_stall", 64'(axi.RLAST), 64'(i == len));
         end
         axi.RREADY = 1'b1;
         wait_for(4, "rvalid");
         chk("rdata", axi.RDATA, expd);
         chk("rresp", 64'(axi.RRESP), 64'(oor ? 2'b10 : 2'b00));
         chk("rlast", 64'(axi.RLAST), 64'(i == len));
         chk("rid", 64'(axi.RID), 64'(id));
         @(negedge clk);
         a = a + (32'd1 << size);
      end
      axi.RREADY = 1'b0;
      chk("rvalid_end", 64'(axi.RVALID), 64'(0));
   endtask

   initial begin
      logic [31:0] ra;
      int          rl, nb;
      logic [1:0]  rs;

      bus_idle();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_awready", 64'(axi.AWREADY), 64'(0));
      chk("rst_wready",  64'(axi.WREADY),  64'(0));
      chk("rst_bvalid",  64'(axi.BVALID),  64'(0));
      chk("rst_bid",     64'(axi.BID),     64'(0));
      chk("rst_bresp",   64'(axi.BRESP),   64'(0));
      chk("rst_arready", 64'(axi.ARREADY), 64'(0));
      chk("rst_rvalid",  64'(axi.RVALID),  64'(0));
      chk("rst_rlast",   64'(axi.RLAST),   64'(0));
      chk("rst_rid",     64'(axi.RID),     64'(0));
      chk("rst_rresp",   64'(axi.RRESP),   64'(0));
      chk("rst_rdata",   axi.RDATA,        64'(0));
      reset = 1'b0;
      #1;
      chk("awready_before_edge", 64'(axi.AWREADY), 64'(0));
      @(negedge clk);
      chk("awready_after_edge", 64'(axi.AWREADY), 64'(1));
      chk("arready_after_edge", 64'(axi.ARREADY), 64'(1));

      // Fill the whole array so every in-range word has a known model value.
      for (int k = 0; k < MEM_WORDS / 16; k++) begin
         for (int i = 0; i < 16; i++) begin
            wd_q.push_back({$urandom, $urandom});
            ws_q.push_back(8'hFF);
         end
         do_write(1'b0, 32'(k * 128), 15, 2'd3, 0);
      end

      // Single-beat write/read.
      wd_q.push_back(64'h0123_4567_89AB_CDEF); ws_q.push_back(8'hFF);
      do_write(1'b1, 32'h10, 0, 2'd3, 0);
      do_read(1'b0, 32'h10, 0, 2'd3, 0);

      // 16-beat INCR, data = beat index.
      for (int i = 0; i < 16; i++) begin
         wd_q.push_back(64'(i)); ws_q.push_back(8'hFF);
      end
      do_write(1'b1, 32'h100, 15, 2'd3, 0);
      do_read(1'b0, 32'h100, 15, 2'd3, 0);

      // Partial strobe over an all-ones word.
      wd_q.push_back(64'hFFFF_FFFF_FFFF_FFFF); ws_q.push_back(8'hFF);
      do_write(1'b0, 32'h200, 0, 2'd3, 0);
      wd_q.push_back(64'h0); ws_q.push_back(8'h0F);
      do_write(1'b0, 32'h200, 0, 2'd3, 0);
      chk("partial_model", mem_m[32'h200 >> 3], 64'hFFFF_FFFF_0000_0000);
      do_read(1'b0, 32'h200, 0, 2'd3, 0);

      // Backpressure on R and B.
      do_read(1'b1, 32'h100, 3, 2'd3, 1);
      wd_q.push_back({$urandom, $urandom}); ws_q.push_back(8'hFF);
      do_write(1'b1, 32'h180, 0, 2'd3, 5);
      do_read(1'b0, 32'h180, 0, 2'd3, 0);

      // Out-of-range write must not alias onto word 0.
      wd_q.push_back(64'hDEAD_BEEF_DEAD_BEEF); ws_q.push_back(8'hFF);
      do_write(1'b1, 32'h2000, 0, 2'd3, 0);
      do_read(1'b0, 32'h0, 0, 2'd3, 0);

      // Early WLAST (LEN=3, 2 beats) and late WLAST (LEN=1, 3 beats).
      for (int i = 0; i < 2; i++) begin wd_q.push_back({$urandom, $urandom}); ws_q.push_back(8'hFF); end
      do_write(1'b1, 32'h300, 3, 2'd3, 0);
      for (int i = 0; i < 3; i++) begin wd_q.push_back({$urandom, $urandom}); ws_q.push_back(8'hFF); end
      do_write(1'b0, 32'h340, 1, 2'd3, 0);
      do_read(1'b0, 32'h300, 2, 2'd3, 0);
      do_read(1'b0, 32'h340, 2, 2'd3, 0);

      // Bursts crossing the top of memory.
      do_read(1'b1, 32'h1FF8, 1, 2'd3, 0);
      for (int i = 0; i < 4; i++) begin wd_q.push_back({$urandom, $urandom}); ws_q.push_back(8'hFF); end
      do_write(1'b1, 32'h1FF0, 3, 2'd3, 0);
      do_read(1'b0, 32'h1FF0, 3, 2'd3, 2);

      // Random mix of bursts, sizes, strobes and backpressure.
      for (int t = 0; t < 40; t++) begin
         ra = 32'($urandom_range(0, MEM_BYTES + 64));
         rl = int'($urandom_range(0, 15));
         rs = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            nb = rl + 1;
            if ($urandom_range(0, 7) == 0) nb = int'($urandom_range(1, 17));
            for (int i = 0; i < nb; i++) begin
               wd_q.push_back({$urandom, $urandom});
               ws_q.push_back(8'($urandom));
            end
            do_write(1'($urandom), ra, rl, rs, int'($urandom_range(0, 3)));
         end else begin
            do_read(1'($urandom), ra, rl, rs, 2);
         end
      end

      // Reset during beat 2 of an 8-beat write.
      axi.AWID = 1'b1; axi.AWADDR = 32'h400; axi.AWLEN = 4'd7; axi.AWSIZE = 2'd3;
      axi.AWVALID = 1'b1;
      wait_for(0, "awready");
      @(negedge clk);
      axi.AWVALID = 1'b0;
      for (int i = 0; i < 2; i++) begin
         axi.WDATA = {$urandom, $urandom}; axi.WSTRB = 8'hFF; axi.WLAST = 1'b0;
         axi.WVALID = 1'b1;
         mem_m[(32'h400 >> 3) + i] = axi.WDATA;
         wait_for(1, "wready");
         @(negedge clk);
      end
      axi.WDATA = {$urandom, $urandom};
      reset = 1'b1;
      #1;
      chk("midrst_bvalid", 64'(axi.BVALID), 64'(0));
      chk("midrst_wready", 64'(axi.WREADY), 64'(0));
      repeat (2) @(negedge clk);
      chk("midrst_bvalid_held", 64'(axi.BVALID), 64'(0));
      axi.WVALID = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_awready", 64'(axi.AWREADY), 64'(1));
      repeat (3) begin
         @(negedge clk);
         chk("midrst_no_b", 64'(axi.BVALID), 64'(0));
      end
      do_read(1'b0, 32'h400, 2, 2'd3, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi64_slave_mem.md
Name: axi64_slave_mem

Overview:
- Synthesizable 64-bit AXI3 slave memory on the DMA controller's AXI master port (AW/W/B/AR/R channel 0).
- Serves DMA read bursts and absorbs DMA write bursts.
- Lets the bench run register-level and data-integrity checks against real RTL instead of a behavioural responder.
- Independent read and write engines; one outstanding transaction per direction.

Parameters:
- ID_W, 1: width of AWID/WID/BID/ARID/RID.
- ADDR_W, 32: AXI address width.
- MEM_AW, 10: log2 of memory depth in 64-bit words (default 1024 words = 8 KiB).
- WAIT_CYCLES, 3: ready-stall length, used only when AXI_MEM_WAIT_EN is defined.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- AWID  in  ID_W  write address ID.
- AWADDR  in  ADDR_W  write burst start address.
- AWLEN  in  4  beats-1.
- AWSIZE  in  2  bytes per beat = 1<<AWSIZE.
- AWVALID  in  1 / AWREADY  out  1  AW handshake.
- WID  in  ID_W  write data ID (ignored).
- WDATA  in  64  write data.
- WSTRB  in  8  byte enables.
- WLAST  in  1  last write beat.
- WVALID  in  1 / WREADY  out  1  W handshake.
- BID  out  ID_W  echoed AWID.
- BRESP  out  2  write response.
- BVALID  out  1 / BREADY  in  1  B handshake.
- ARID  in  ID_W  read address ID.
- ARADDR  in  ADDR_W  read burst start address.
- ARLEN  in  4  beats-1.
- ARSIZE  in  2  bytes per beat = 1<<ARSIZE.
- ARVALID  in  1 / ARREADY  out  1  AR handshake.
- RID  out  ID_W  echoed ARID.
- RDATA  out  64  read data.
- RRESP  out  2  read response.
- RLAST  out  1  last read beat.
- RVALID  out  1 / RREADY  in  1  R handshake.

Behaviour:
- Reset, async assert:
  - AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0.
  - ARREADY=0, RVALID=0, RLAST=0, RID=0, RRESP=0, RDATA=0.
  - Both FSMs go to IDLE. Memory array is not reset.
  - AWREADY/ARREADY go high on the first clk edge after reset deasserts.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch ID, address, LEN and SIZE; clear beat counter and error flag; go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID&WREADY writes the bytes with WSTRB set into word addr[MEM_AW+2:3]. Address then increments by 1<<SIZE (INCR only; LEN/SIZE fields are not checked beyond that). Counter increments.
  - Leave W_DATA on the beat with WLAST=1.
  - Error flag sets if WLAST arrives with count≠LEN. Error flag also sets if count reaches LEN without WLAST; beats are still accepted until WLAST.
  - W_RESP: BVALID=1 with BID=latched ID. BRESP=2'b10 (SLVERR) on error or on any out-of-range beat, else 2'b00. Hold until BREADY, then go to W_IDLE.
  - BVALID rises one cycle after the WLAST handshake.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On handshake, latch ID, address, LEN and SIZE.
  - First RVALID appears the cycle after the AR handshake.
  - Beats run back-to-back while RREADY=1.
  - RDATA, RRESP and RLAST hold while RVALID&!RREADY.
  - RLAST=1 on beat index LEN. Return to R_IDLE on the last handshake.
- Out of range: an address at or above 8<<MEM_AW bytes is out of range.
  - Write beat: discarded, and the burst's BRESP is SLVERR.
  - Read beat: RDATA=0, RRESP=2'b10 for that beat only.
- Address crossing the top of memory mid-burst: no wrap. Beats past the top are out of range.
- Read and write in the same cycle to the same word: the read returns the pre-write data. Writes commit on the clock edge.
- Reset mid-burst: the burst is abandoned, no B/R response is issued, and memory keeps the beats already written.

Optional Feature:
- AXI_MEM_WAIT_EN defined:
  - On entry to W_IDLE/R_IDLE, AWREADY/ARREADY stay low for WAIT_CYCLES cycles before rising.
  - On entry to W_DATA, WREADY stays low for WAIT_CYCLES cycles.
  - A shared-structure 8-bit down-counter per channel implements the stall.
- Not defined: ready is asserted immediately as described above; the counters are absent.

Decomposition:
- Package axi_mem_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Write FSM state enum, read FSM state enum.
  - Function computing the next address from SIZE.
- Sub-module axi_mem_array: 2^MEM_AW x 64 array with one byte-strobed write port and one read port.

Test Plan:
- Single-beat write then read: AW addr=0x10, LEN=0, WDATA=0x0123456789ABCDEF, WSTRB=0xFF -> BRESP=0 one cycle after W. Read of 0x10 returns the same data with RLAST=1 and RRESP=0.
- 16-beat INCR write to 0x100, data = beat index, then 16-beat read -> RDATA 0..15 in order, RLAST only on beat 15, BID/RID echo AWID=1/ARID=0.
- Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF, then WSTRB=0x0F with data 0 to the same word -> readback 0xFFFF_FFFF_0000_0000.
- Backpressure: RREADY toggled 0/1 every cycle on a 4-beat read -> RDATA/RLAST stable while stalled, 4 handshakes total. BREADY held low 5 cycles -> BVALID held.
- Errors:
  - Write to 0x2000 (out of range, MEM_AW=10) -> BRESP=2'b10 and memory unchanged.
  - AWLEN=3 with WLAST on beat 1 -> BRESP=2'b10.
  - Read at 0x1FF8 with LEN=1 -> beat0 RRESP=0, beat1 RRESP=2'b10 with RDATA=0.
- Reset asserted during beat 2 of an 8-beat write -> BVALID never rises, AWREADY=1 one cycle after deassert, beats 0-1 present in memory.
